md_pad_responder: RTL and testbench

Emulates the device end of the Mega Drive DB9 pad protocol. The host drives the select line (TH). The block answers on the six data pins with the 3-button or 6-button multiplexed pattern built from an active-high button vector. It sits on the user-port side, facing our existing `joy_db9md` host reader, and lets a core present its own inputs (USB or keyboard) as a physical MD pad. It also serves as the bench model for `joy_db9md`.

---
 rtl/md_pad_pkg.sv | 93 +++++++++
 rtl/md_pad_responder_sync.sv | 31 +++
 rtl/md_pad_responder.sv | 74 +++++++
 tb/tb_md_pad_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pad_pkg.sv
// Shared constants and pin-pattern helper for the Mega Drive pad responder.
// Pure combinational definitions; no state, no flow control.
package md_pad_pkg;

    localparam int BTN_R     = 0;
    localparam int BTN_L     = 1;
    localparam int BTN_D     = 2;
    localparam int BTN_U     = 3;
    localparam int BTN_B     = 4;
    localparam int BTN_C     = 5;
    localparam int BTN_A     = 6;
    localparam int BTN_START = 7;
    localparam int BTN_MODE  = 8;
    localparam int BTN_X     = 9;
    localparam int BTN_Y     = 10;
    localparam int BTN_Z     = 11;

    localparam int PIN_P1 = 0;
    localparam int PIN_P2 = 1;
    localparam int PIN_P3 = 2;
    localparam int PIN_P4 = 3;
    localparam int PIN_P6 = 4;
    localparam int PIN_P9 = 5;

    localparam logic [2:0] CNT_SAT = 3'd5;

    typedef enum logic [2:0] {
        PAT_NORM_HI,
        PAT_NORM_LO,
        PAT_ID,
        PAT_EXT,
        PAT_ALL_HI
    } md_pat_e;

    function automatic md_pat_e md_pat_kind(input logic sel, input logic [2:0] cnt,
                                            input logic six);
        if (six && cnt == 3'd3) return sel ? PAT_EXT : PAT_ID;
        if (six && cnt == 3'd4 && !sel) return PAT_ALL_HI;
        return sel ? PAT_NORM_HI : PAT_NORM_LO;
    endfunction

    // Returns active-low pin levels indexed by PIN_*.
    function automatic logic [5:0] md_pattern(input logic sel, input logic [2:0] cnt,
                                              input logic [11:0] buttons, input logic six);
        logic [5:0] p;
        p = '1;
        case (md_pat_kind(sel, cnt, six))
            PAT_NORM_HI: begin
                p[PIN_P9] = ~buttons[BTN_C];
                p[PIN_P6] = ~buttons[BTN_B];
                p[PIN_P4] = ~buttons[BTN_R];
                p[PIN_P3] = ~buttons[BTN_L];
                p[PIN_P2] = ~buttons[BTN_D];
                p[PIN_P1] = ~buttons[BTN_U];
            end
            PAT_EXT: begin
                p[PIN_P9] = ~buttons[BTN_C];
                p[PIN_P6] = ~buttons[BTN_B];
                p[PIN_P4] = ~buttons[BTN_MODE];
                p[PIN_P3] = ~buttons[BTN_X];
                p[PIN_P2] = ~buttons[BTN_Y];
                p[PIN_P1] = ~buttons[BTN_Z];
            end
            PAT_NORM_LO: begin
                p[PIN_P9] = ~buttons[BTN_START];
                p[PIN_P6] = ~buttons[BTN_A];
                p[PIN_P4] = 1'b0;
                p[PIN_P3] = 1'b0;
                p[PIN_P2] = ~buttons[BTN_D];
                p[PIN_P1] = ~buttons[BTN_U];
            end
            PAT_ID: begin
                p[PIN_P9] = ~buttons[BTN_START];
                p[PIN_P6] = ~buttons[BTN_A];
                p[PIN_P4] = 1'b0;
                p[PIN_P3] = 1'b0;
                p[PIN_P2] = 1'b0;
                p[PIN_P1] = 1'b0;
            end
            PAT_ALL_HI: begin
                p[PIN_P9] = ~buttons[BTN_START];
                p[PIN_P6] = ~buttons[BTN_A];
                p[PIN_P4] = 1'b1;
                p[PIN_P3] = 1'b1;
                p[PIN_P2] = 1'b1;
                p[PIN_P1] = 1'b1;
            end
            default: p = '1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/md_pad_responder_sync.sv
// Select-line synchronizer with edge detect; sel_s_o lags sel_i by SYNC_STAGES clocks,
// rise_o/fall_o are combinational on the synced value. No flow control.
module md_sel_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sel_i,
    output logic sel_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sel_prev_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q     <= '1;
            sel_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sel_i};
            sel_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sel_s_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sel_s_o & ~sel_prev_q;
    assign fall_o  = ~sel_s_o & sel_prev_q;

endmodule

// File: rtl/md_pad_responder.sv
// Device side of the MD DB9 pad protocol: select edges step a phase counter that picks the pin pattern.
// Select-to-pin SYNC_STAGES+1 clocks, button-to-pin 1 clock; no backpressure, pins always driven.
module md_pad_responder
    import md_pad_pkg::*;
#(
    parameter bit SIX_BUTTON     = 1'b1,
    parameter int TIMEOUT_CYCLES = 18000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sel_in,
    input  logic [11:0] buttons,
    output logic [5:0]  pad_out,
    output logic        six_active,
    output logic [2:0]  phase
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 15) ? $clog2(TIMEOUT_CYCLES) : 15;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    logic          sel_s;
    logic          rise;
    logic          fall;
    logic          timeout;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [5:0]    pad_q, pad_d;

    md_sel_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .sel_i   (sel_in),
        .sel_s_o (sel_s),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // A fall on the timeout clock counts from zero, so the fresh cycle starts at 1.
    always_comb begin
        timeout = (timer_q == TMAX);
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (fall) begin
            if (timeout)              cnt_d = 3'd1;
            else if (cnt_q == CNT_SAT) cnt_d = CNT_SAT;
            else                      cnt_d = cnt_q + 3'd1;
        end else if (timeout) begin
            cnt_d = 3'd0;
        end
        if (rise || fall)  timer_d = '0;
        else if (!timeout) timer_d = timer_q + 1'b1;
        pad_d = md_pattern(sel_s, cnt_d, buttons, SIX_BUTTON);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q <= '0;
            cnt_q   <= 3'd0;
            pad_q   <= '1;
        end else begin
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
        end
    end

    assign pad_out    = pad_q;
    assign phase      = cnt_q;
    assign six_active = SIX_BUTTON && (cnt_q == 3'd3 || cnt_q == 3'd4);

endmodule

// File: tb/tb_md_pad_responder.sv
// Bench for md_pad_responder: directed protocol scenarios plus randomized select/button traffic
// compared against a clock-level reference model of the pad behaviour.
module tb_md_pad_responder;

    localparam int S = 2;
    localparam int T = 18000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel_in;
    logic [11:0] buttons;
    logic [5:0]  pad_out, pad3;
    logic        six_active, six3;
    logic [2:0]  phase, phase3;

    int checks = 0;
    int errors = 0;

    bit         samp[$];
    int         m_cnt;
    int         m_idle;
    logic [5:0] m_pad, m_pad3;

    always #5 clk = ~clk;

    md_pad_responder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sel_in     (sel_in),
        .buttons    (buttons),
        .pad_out    (pad_out),
        .six_active (six_active),
        .phase      (phase)
    );

    md_pad_responder #(.SIX_BUTTON(1'b0)) dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .sel_in     (sel_in),
        .buttons    (buttons),
        .pad_out    (pad3),
        .six_active (six3),
        .phase      (phase3)
    );

    // Pin word {P9,P6,P4,P3,P2,P1}, active low, straight from the protocol table.
    function automatic logic [5:0] ref_pat(input bit sel, input int c, input logic [11:0] b,
                                           input bit six);
        if (six && c == 3)
            return sel ? {~b[5], ~b[4], ~b[8], ~b[9], ~b[10], ~b[11]} : {~b[7], ~b[6], 4'b0000};
        if (six && c == 4 && !sel)
            return {~b[7], ~b[6], 4'b1111};
        return sel ? {~b[5], ~b[4], ~b[0], ~b[1], ~b[2], ~b[3]}
                   : {~b[7], ~b[6], 2'b00, ~b[2], ~b[3]};
    endfunction

    // The pad sees sel_in S clocks late and reacts to a change one clock after that.
    task automatic model_tick();
        bit seen, prev, tmo;
        if (!reset_n) begin
            samp = {};
            repeat (S + 2) samp.push_back(1'b1);
            m_cnt  = 0;
            m_idle = 0;
            m_pad  = '1;
            m_pad3 = '1;
            return;
        end
        samp.push_front(sel_in);
        seen = samp[S];
        prev = samp[S+1];
        void'(samp.pop_back());
        tmo = (m_idle >= T - 1);
        if (prev && !seen) m_cnt = tmo ? 1 : ((m_cnt < 5) ? m_cnt + 1 : 5);
        else if (tmo)      m_cnt = 0;
        m_idle = (seen != prev) ? 0 : m_idle + 1;
        m_pad  = ref_pat(seen, m_cnt, buttons, 1'b1);
        m_pad3 = ref_pat(seen, m_cnt, buttons, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic pulse(input int lo, input int hi);
        sel_in = 1'b0;
        repeat (lo) step();
        sel_in = 1'b1;
        repeat (hi) step();
    endtask

    task automatic do_reset(input logic [11:0] b);
        reset_n = 1'b0;
        sel_in  = 1'b1;
        buttons = b;
        step();
        reset_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        sel_in  = 1'b1;
        buttons = '0;
        repeat (3) step();
        checks++; if (pad_out !== 6'h3F) begin errors++; $display("FAIL reset_pad got %b want %b", pad_out, 6'h3F); end
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
        checks++; if (six_active !== 1'b0) begin errors++; $display("FAIL reset_six got %b want 0", six_active); end
        checks++; if (pad3 !== 6'h3F) begin errors++; $display("FAIL reset_pad3 got %b want %b", pad3, 6'h3F); end
    endtask

    task automatic test_button_latency();
        reset_n = 1'b1;
        repeat (3) step();
        buttons = 12'h001;
        step();
        checks++; if (pad_out !== 6'b110111) begin errors++; $display("FAIL btn_R got %b want %b", pad_out, 6'b110111); end
        checks++; if (pad_out !== m_pad) begin errors++; $display("FAIL btn_R_model got %b want %b", pad_out, m_pad); end
    endtask

    task automatic test_sel_latency();
        sel_in = 1'b0;
        repeat (2) step();
        checks++; if (pad_out !== 6'b110111) begin errors++; $display("FAIL sel_early got %b want %b", pad_out, 6'b110111); end
        step();
        checks++; if (pad_out !== 6'b110011) begin errors++; $display("FAIL sel_lo got %b want %b", pad_out, 6'b110011); end
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL sel_phase got %0d want 1", phase); end
        buttons = 12'h081;
        step();
        checks++; if (pad_out !== 6'b010011) begin errors++; $display("FAIL start_lo got %b want %b", pad_out, 6'b010011); end
    endtask

    task automatic test_six_cycle();
        do_reset(12'h800);
        pulse(12, 12);
        pulse(12, 12);
        sel_in = 1'b0;
        repeat (12) step();
        checks++; if (pad_out !== 6'b110000) begin errors++; $display("FAIL six_id got %b want %b", pad_out, 6'b110000); end
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL six_phase3 got %0d want 3", phase); end
        checks++; if (six_active !== 1'b1) begin errors++; $display("FAIL six_act3 got %b want 1", six_active); end
        checks++; if (pad3 !== 6'b110011) begin errors++; $display("FAIL three_btn_lo got %b want %b", pad3, 6'b110011); end
        checks++; if (six3 !== 1'b0) begin errors++; $display("FAIL three_btn_six got %b want 0", six3); end
        sel_in = 1'b1;
        repeat (12) step();
        checks++; if (pad_out !== 6'b111110) begin errors++; $display("FAIL six_ext got %b want %b", pad_out, 6'b111110); end
        checks++; if (six_active !== 1'b1) begin errors++; $display("FAIL six_act3h got %b want 1", six_active); end
        sel_in = 1'b0;
        repeat (12) step();
        checks++; if (pad_out !== 6'b111111) begin errors++; $display("FAIL six_allhi got %b want %b", pad_out, 6'b111111); end
        checks++; if (phase !== 3'd4) begin errors++; $display("FAIL six_phase4 got %0d want 4", phase); end
        checks++; if (six_active !== 1'b1) begin errors++; $display("FAIL six_act4 got %b want 1", six_active); end
        sel_in = 1'b1;
        repeat (12) step();
        checks++; if (pad_out !== 6'b111111) begin errors++; $display("FAIL six_hi4 got %b want %b", pad_out, 6'b111111); end
        pulse(12, 12);
        checks++; if (six_active !== 1'b0) begin errors++; $display("FAIL six_act5 got %b want 0", six_active); end
        checks++; if (phase !== 3'd5) begin errors++; $display("FAIL six_phase5 got %0d want 5", phase); end
    endtask

    task automatic test_timeout();
        do_reset(12'h800);
        repeat (3) pulse(4, 4);
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL to_pre got %0d want 3", phase); end
        repeat (T - 20) step();
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL to_hold got %0d want 3", phase); end
        repeat (40) step();
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL to_clear got %0d want 0", phase); end
        sel_in = 1'b0;
        repeat (3) step();
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL to_next got %0d want 1", phase); end
        checks++; if (pad_out !== 6'b110011) begin errors++; $display("FAIL to_next_pad got %b want %b", pad_out, 6'b110011); end
    endtask

    task automatic test_timeout_edge();
        do_reset(12'h800);
        repeat (2) pulse(4, 4);
        sel_in = 1'b0;
        repeat (4) step();
        sel_in = 1'b1;
        repeat (T) step();
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL toe_pre got %0d want 3", phase); end
        sel_in = 1'b0;
        repeat (3) step();
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL toe_phase got %0d want 1", phase); end
        checks++; if (phase !== 3'(m_cnt)) begin errors++; $display("FAIL toe_model got %0d want %0d", phase, m_cnt); end
        checks++; if (pad_out !== 6'b110011) begin errors++; $display("FAIL toe_pad got %b want %b", pad_out, 6'b110011); end
    endtask

    task automatic test_reset_mid();
        do_reset(12'h800);
        repeat (2) pulse(4, 4);
        sel_in = 1'b0;
        repeat (4) step();
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL rm_pre got %0d want 3", phase); end
        reset_n = 1'b0;
        step();
        checks++; if (pad_out !== 6'h3F) begin errors++; $display("FAIL rm_pad got %b want %b", pad_out, 6'h3F); end
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rm_phase got %0d want 0", phase); end
        checks++; if (six_active !== 1'b0) begin errors++; $display("FAIL rm_six got %b want 0", six_active); end
        reset_n = 1'b1;
        repeat (2) step();
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rm_wait got %0d want 0", phase); end
        step();
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL rm_next got %0d want 1", phase); end
        checks++; if (pad_out !== 6'b110011) begin errors++; $display("FAIL rm_next_pad got %b want %b", pad_out, 6'b110011); end
    endtask

    task automatic test_random();
        int hold = 0;
        do_reset(12'h000);
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                sel_in = ~sel_in;
                hold   = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 7) == 0) buttons = 12'($urandom);
            reset_n = ($urandom_range(0, 149) != 0);
            step();
            checks++; if (pad_out !== m_pad) begin errors++; $display("FAIL rnd_pad cyc %0d got %b want %b", i, pad_out, m_pad); end
            checks++; if (phase !== 3'(m_cnt)) begin errors++; $display("FAIL rnd_phase cyc %0d got %0d want %0d", i, phase, m_cnt); end
            checks++; if (six_active !== (m_cnt == 3 || m_cnt == 4)) begin errors++; $display("FAIL rnd_six cyc %0d got %b want %b", i, six_active, (m_cnt == 3 || m_cnt == 4)); end
            checks++; if (pad3 !== m_pad3) begin errors++; $display("FAIL rnd_pad3 cyc %0d got %b want %b", i, pad3, m_pad3); end
            checks++; if (six3 !== 1'b0) begin errors++; $display("FAIL rnd_six3 cyc %0d got %b want 0", i, six3); end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        sel_in  = 1'b1;
        buttons = '0;
        test_reset();
        test_button_latency();
        test_sel_latency();
        test_six_cycle();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
